// File: rtl/led_pattern_engine_if.sv
// rtl/led_pattern_engine_if.sv - mode/data/LED signal bundle for the LED pattern engine
interface led_pattern_engine_if #(
  parameter int WIDTH = 7
);
  logic [2:0]       led_control;
  logic [WIDTH-1:0] score;
  logic [WIDTH-1:0] fake_score;
  logic [WIDTH-1:0] speed_led;
  logic             tick;
  logic [WIDTH-1:0] leds_out;

  // Game side: selects the mode and supplies patterns, observes the LEDs
  modport master (
    output led_control, score, fake_score, speed_led,
    input  tick, leds_out
  );

  // Engine side
  modport slave (
    input  led_control, score, fake_score, speed_led,
    output tick, leds_out
  );
endinterface

// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - registered LED bank driver with blink and bouncing chase modes
module led_pattern_engine #(
  parameter int               WIDTH       = 7,
  parameter int               TICK_DIV    = 25000000,
  parameter int               BLINK_TICKS = 1,
  parameter logic [WIDTH-1:0] RESET_PAT   = 7'b1000101
) (
  input logic               clk,
  input logic               reset,
  led_pattern_engine_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int CW = $clog2(WIDTH);

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [CW-1:0] POS_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] POS_PEN    = CW'(WIDTH - 2);

  typedef enum logic [2:0] {
    MODE_DARK  = 3'b000,
    MODE_RESET = 3'b001,
    MODE_WAIT  = 3'b010,
    MODE_SCORE = 3'b011,
    MODE_FAKE  = 3'b100,
    MODE_BLINK = 3'b101,
    MODE_SPEED = 3'b110,
    MODE_CHASE = 3'b111
  } mode_t;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  mode_t            mode_q, mode_d;
  logic [PW-1:0]    prescaler_q, prescaler_d;
  logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
  logic             blink_on_q, blink_on_d;
  logic [CW-1:0]    chase_pos_q, chase_pos_d;
  dir_t             chase_dir_q, chase_dir_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic             mode_change;
  logic             wrap;

  assign bus.tick     = tick_q;
  assign bus.leds_out = leds_q;

  // State register: animation state plus the registered LED/tick outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= MODE_DARK;
      prescaler_q <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      chase_pos_q <= '0;
      chase_dir_q <= DIR_UP;
      tick_q      <= 1'b0;
      leds_q      <= '0;
    end else begin
      mode_q      <= mode_d;
      prescaler_q <= prescaler_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      chase_pos_q <= chase_pos_d;
      chase_dir_q <= chase_dir_d;
      tick_q      <= tick_d;
      leds_q      <= leds_d;
    end
  end

  // Next state: a mode change restarts every animation counter and beats a coincident wrap
  always_comb begin
    mode_d      = mode_t'(bus.led_control);
    mode_change = (mode_d != mode_q);
    wrap        = (prescaler_q == PRE_LAST);
    prescaler_d = prescaler_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    chase_pos_d = chase_pos_q;
    chase_dir_d = chase_dir_q;
    tick_d      = 1'b0;
    if (mode_change) begin
      prescaler_d = '0;
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
      chase_pos_d = '0;
      chase_dir_d = DIR_UP;
    end else begin
      prescaler_d = wrap ? '0 : prescaler_q + PW'(1);
      tick_d      = wrap;
      if (wrap) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          blink_on_d  = ~blink_on_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
        if (chase_dir_q == DIR_UP) begin
          if (chase_pos_q == POS_LAST) begin
            chase_pos_d = POS_PEN;
            chase_dir_d = DIR_DOWN;
          end else begin
            chase_pos_d = chase_pos_q + CW'(1);
          end
        end else begin
          if (chase_pos_q == '0) begin
            chase_pos_d = CW'(1);
            chase_dir_d = DIR_UP;
          end else begin
            chase_pos_d = chase_pos_q - CW'(1);
          end
        end
      end
    end
  end

  // Output select: built from the post-edge state so a restarted mode shows its first frame at once
  always_comb begin
    leds_d = '0;
    unique case (mode_d)
      MODE_DARK:  leds_d = '0;
      MODE_RESET: leds_d = RESET_PAT;
      MODE_WAIT:  leds_d = '1;
      MODE_SCORE: leds_d = bus.score;
      MODE_FAKE:  leds_d = bus.fake_score;
      MODE_BLINK: leds_d = blink_on_d ? bus.score : '0;
      MODE_SPEED: leds_d = bus.speed_led;
      MODE_CHASE: leds_d = WIDTH'(1) << chase_pos_d;
      default:    leds_d = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - self-checking bench for led_pattern_engine
module tb_led_pattern_engine;
  localparam int W  = 7;
  localparam int TD = 4;
  localparam int BT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_pattern_engine_if #(.WIDTH(W)) ifc ();

  led_pattern_engine #(
    .WIDTH(W), .TICK_DIV(TD), .BLINK_TICKS(BT), .RESET_PAT(7'b1000101)
  ) dut (
    .clk(clk), .reset(rst), .bus(ifc)
  );

  int passed = 0;
  int total  = 0;

  // reference state: edges since the last restart (reset or mode change) and the current mode
  int         m_k    = 0;
  logic [2:0] m_mode = 3'd0;

  typedef struct {
    logic [2:0] ctrl;
    logic [6:0] s;
    logic [6:0] f;
    logic [6:0] sp;
    logic [6:0] exp;
  } vec_t;

  vec_t       vecs [9];
  logic [6:0] chase_seq [15];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [6:0] model_leds(input logic [2:0] mode, input logic [6:0] s,
                                            input logic [6:0] f, input logic [6:0] sp, input int k);
    int n, m, pos;
    n   = k / TD;
    m   = n % (2 * W - 2);
    pos = (m < W) ? m : (2 * W - 2 - m);
    case (mode)
      3'd0: return 7'h00;
      3'd1: return 7'b1000101;
      3'd2: return 7'h7F;
      3'd3: return s;
      3'd4: return f;
      3'd5: return (((n / BT) % 2) == 0) ? s : 7'h00;
      3'd6: return sp;
      default: return 7'(1 << pos);
    endcase
  endfunction

  function automatic logic model_tick(input int k);
    return (k != 0) && ((k % TD) == 0);
  endfunction

  task automatic step(input logic [2:0] c, input logic [6:0] s, input logic [6:0] f,
                      input logic [6:0] sp);
    ifc.led_control = c;
    ifc.score       = s;
    ifc.fake_score  = f;
    ifc.speed_led   = sp;
    @(posedge clk);
    if (c != m_mode) begin
      m_mode = c;
      m_k    = 0;
    end else begin
      m_k++;
    end
    #1;
    check("model_leds", int'(ifc.leds_out), int'(model_leds(m_mode, s, f, sp, m_k)));
    check("model_tick", int'(ifc.tick), int'(model_tick(m_k)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] c;
    int         guard;

    vecs[0] = '{3'd0, 7'h2A, 7'h15, 7'h7F, 7'h00};
    vecs[1] = '{3'd1, 7'h2A, 7'h15, 7'h7F, 7'h45};
    vecs[2] = '{3'd2, 7'h2A, 7'h15, 7'h7F, 7'h7F};
    vecs[3] = '{3'd3, 7'h2A, 7'h15, 7'h7F, 7'h2A};
    vecs[4] = '{3'd4, 7'h2A, 7'h15, 7'h7F, 7'h15};
    vecs[5] = '{3'd5, 7'h2A, 7'h15, 7'h7F, 7'h2A};
    vecs[6] = '{3'd6, 7'h2A, 7'h15, 7'h7F, 7'h7F};
    vecs[7] = '{3'd3, 7'h01, 7'h15, 7'h7F, 7'h01};
    vecs[8] = '{3'd3, 7'h03, 7'h15, 7'h7F, 7'h03};
    chase_seq = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h20,
                  7'h10, 7'h08, 7'h04, 7'h02, 7'h01, 7'h02, 7'h04};

    ifc.led_control = 3'd0;
    ifc.score       = 7'h00;
    ifc.fake_score  = 7'h00;
    ifc.speed_led   = 7'h00;

    // reset state
    @(posedge clk);
    #1;
    check("reset_leds", int'(ifc.leds_out), 0);
    check("reset_tick", int'(ifc.tick), 0);
    rst = 1'b0;

    // mode table, including the score pass-through change in SCORE mode
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].ctrl, vecs[i].s, vecs[i].f, vecs[i].sp);
      check($sformatf("vec%0d", i), int'(ifc.leds_out), int'(vecs[i].exp));
    end

    // bouncing chase held for 60 cycles
    for (int i = 0; i < 60; i++) begin
      step(3'd7, 7'h2A, 7'h15, 7'h7F);
      check("chase_seq", int'(ifc.leds_out), int'(chase_seq[i / TD]));
      check("chase_tick", int'(ifc.tick), int'(i != 0 && (i % TD) == 0));
    end

    // blink with score 55: 8 cycles on, 8 off
    for (int i = 0; i < 32; i++) begin
      step(3'd5, 7'h55, 7'h15, 7'h7F);
      check("blink", int'(ifc.leds_out), (((i / 8) % 2) == 0) ? 32'h55 : 32'h0);
    end

    // switch CHASE -> BLINK exactly on a prescaler-wrap cycle
    step(3'd7, 7'h2A, 7'h15, 7'h7F);
    guard = 0;
    while ((m_k % TD) != TD - 1 && guard < 10) begin
      step(3'd7, 7'h2A, 7'h15, 7'h7F);
      guard++;
    end
    check("wrap_align", int'((m_k % TD) == TD - 1), 1);
    step(3'd5, 7'h2A, 7'h15, 7'h7F);
    check("wrap_switch_tick", int'(ifc.tick), 0);
    check("wrap_switch_leds", int'(ifc.leds_out), 32'h2A);
    step(3'd5, 7'h2A, 7'h15, 7'h7F);
    step(3'd5, 7'h2A, 7'h15, 7'h7F);
    step(3'd7, 7'h2A, 7'h15, 7'h7F);
    check("chase_restart", int'(ifc.leds_out), 32'h01);

    // asynchronous reset mid-run, observed before any clock edge
    step(3'd2, 7'h2A, 7'h15, 7'h7F);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_leds", int'(ifc.leds_out), 0);
    check("async_reset_tick", int'(ifc.tick), 0);
    m_k    = 0;
    m_mode = 3'd0;
    @(posedge clk);
    #1;
    check("held_reset_leds", int'(ifc.leds_out), 0);
    rst = 1'b0;
    step(3'd0, 7'h2A, 7'h15, 7'h7F);
    step(3'd7, 7'h2A, 7'h15, 7'h7F);
    check("post_reset_chase", int'(ifc.leds_out), 32'h01);

    // randomized modes and data against the reference model
    c = 3'd7;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) c = 3'($urandom_range(0, 7));
      step(c, 7'($urandom), 7'($urandom), 7'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
